// File: rtl/param_ralu.sv
// Register ALU: regA/regB operand registers, GPR file, combinational ALU, multi-cycle shifter on regB.
// R/cout are combinational; state updates on the next edge; multi-shift holds busy for N cycles, then pulses done.
module param_ralu #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       op,
    input  logic             cin,
    input  logic             isl,
    input  logic             isr,
    input  logic             sel_a,
    input  logic             wr,
    input  logic [AW-1:0]    adr,
    input  logic [2:0]       v,
    input  logic             sh_start,
    input  logic             sh_dir,
    input  logic [CW-1:0]    sh_cnt,
    output logic [WIDTH-1:0] R,
    output logic             cout,
    output logic             osl,
    output logic             osr,
    output logic [2:0]       flags,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_clamp;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             w_shl;
    logic             w_shr;
    logic             w_ldb;

    logic [WIDTH-1:0] r_rega;
    logic [WIDTH-1:0] r_regb;
    logic [WIDTH-1:0] r_gpr [DEPTH];
    logic             r_osl;
    logic             r_osr;
    logic [2:0]       r_flags;
    logic [WIDTH:0]   w_sum;

    // Carry lives in the top bit; logic ops leave it at zero.
    always_comb begin
        w_sum = '0;
        case (op)
            3'b000:  w_sum = {1'b0, r_rega} + {1'b0, r_regb}  + {{WIDTH{1'b0}}, cin};
            3'b001:  w_sum = {1'b0, r_rega} + {1'b0, ~r_regb} + {{WIDTH{1'b0}}, cin};
            3'b010:  w_sum = {1'b0, r_rega & r_regb};
            3'b011:  w_sum = {1'b0, r_rega | r_regb};
            3'b100:  w_sum = {1'b0, r_rega ^ r_regb};
            3'b101:  w_sum = {1'b0, ~r_rega};
            3'b110:  w_sum = {1'b0, r_rega};
            default: w_sum = {1'b0, r_regb};
        endcase
    end

    assign R     = w_sum[WIDTH-1:0];
    assign cout  = w_sum[WIDTH];
    assign osl   = r_osl;
    assign osr   = r_osr;
    assign flags = r_flags;
    assign busy  = (r_state == SHIFT);
    assign done  = (r_state == DONE);

    assign w_cnt_clamp = (sh_cnt > CW'(WIDTH)) ? CW'(WIDTH) : sh_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // A shift request outranks the single-step regB actions in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_shl       = 1'b0;
        w_shr       = 1'b0;
        w_ldb       = 1'b0;
        case (r_state)
            IDLE: begin
                if (sh_start) begin
                    w_dir_nxt   = sh_dir;
                    w_cnt_nxt   = w_cnt_clamp;
                    w_state_nxt = (w_cnt_clamp != '0) ? SHIFT : DONE;
                end else begin
                    w_shl = (v[2:1] == 2'b01);
                    w_shr = (v[2:1] == 2'b10);
                    w_ldb = (v[2:1] == 2'b11);
                end
            end
            SHIFT: begin
                w_shl     = ~r_dir;
                w_shr     = r_dir;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Non-blocking updates give every load the pre-edge regA/regB/GPR values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rega  <= '0;
            r_regb  <= '0;
            r_osl   <= 1'b0;
            r_osr   <= 1'b0;
            r_flags <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            if (v[0]) begin
                r_rega <= sel_a ? data_in : r_gpr[adr];
            end
            if (w_shl) begin
                {r_osl, r_regb} <= {r_regb, isl};
            end else if (w_shr) begin
                {r_regb, r_osr} <= {isr, r_regb};
            end else if (w_ldb) begin
                r_regb <= r_gpr[adr];
            end
            if (wr) begin
                r_gpr[adr] <= R;
                r_flags    <= {R[WIDTH-1], (R == '0), cout};
            end
        end
    end

endmodule

// File: tb/tb_param_ralu.sv
module tb_param_ralu;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] data_in;
    logic [2:0] op;
    logic       cin, isl, isr, sel_a, wr;
    logic [2:0] adr;
    logic [2:0] v;
    logic       sh_start, sh_dir;
    logic [2:0] sh_cnt;
    logic [3:0] R;
    logic       cout, osl, osr, busy, done;
    logic [2:0] flags;

    param_ralu #(.WIDTH(4), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .op(op), .cin(cin),
        .isl(isl), .isr(isr), .sel_a(sel_a), .wr(wr), .adr(adr), .v(v),
        .sh_start(sh_start), .sh_dir(sh_dir), .sh_cnt(sh_cnt),
        .R(R), .cout(cout), .osl(osl), .osr(osr), .flags(flags),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic       cin;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       co;
        logic [2:0] fl;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] val;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input string nm, input logic [31:0] val);
        sb.push_back('{nm, val});
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.nm, act, e.val);
            end
        end
    endtask

    // regA <- a, regB <- b, using only the external ports (b goes via GPR[7]).
    task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
        data_in = b; sel_a = 1'b1; v = 3'b001; wr = 1'b0;
        tick();
        v = 3'b000; op = 3'b110; wr = 1'b1; adr = 3'd7;
        tick();
        wr = 1'b0; v = 3'b111; data_in = a; adr = 3'd7;
        tick();
        v = 3'b000;
    endtask

    // Called right after the edge that accepted sh_start.
    task automatic run_shift(input int n, input bit poke, input string nm);
        int nb    = 0;
        int guard = 0;
        expect_v({nm, "_busy_cycles"}, n);
        while (busy === 1'b1 && guard < 50) begin
            nb++;
            guard++;
            if (poke) begin
                sh_start = 1'b1;
                sh_cnt   = 3'd1;
                sh_dir   = ~sh_dir;
            end
            tick();
        end
        sh_start = 1'b0;
        check(nb);
        expect_v({nm, "_done_pulse"}, 1);
        check(done);
        v = 3'b000;
        tick();
        expect_v({nm, "_done_cleared"}, 0);
        check(done);
        expect_v({nm, "_busy_cleared"}, 0);
        check(busy);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 1'b0, 4'b0101, 4'b0101, 4'b1010, 1'b0, 3'b100};
        vecs[1]  = '{3'b001, 1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 3'b100};
        vecs[2]  = '{3'b001, 1'b1, 4'b0101, 4'b0101, 4'b0000, 1'b1, 3'b011};
        vecs[3]  = '{3'b000, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 3'b011};
        vecs[4]  = '{3'b000, 1'b1, 4'b0111, 4'b1000, 4'b0000, 1'b1, 3'b011};
        vecs[5]  = '{3'b010, 1'b1, 4'b1100, 4'b1010, 4'b1000, 1'b0, 3'b100};
        vecs[6]  = '{3'b011, 1'b1, 4'b1100, 4'b1010, 4'b1110, 1'b0, 3'b100};
        vecs[7]  = '{3'b100, 1'b1, 4'b1100, 4'b1010, 4'b0110, 1'b0, 3'b000};
        vecs[8]  = '{3'b101, 1'b1, 4'b1100, 4'b1010, 4'b0011, 1'b0, 3'b000};
        vecs[9]  = '{3'b110, 1'b1, 4'b1100, 4'b1010, 4'b1100, 1'b0, 3'b100};
        vecs[10] = '{3'b111, 1'b1, 4'b1100, 4'b1010, 4'b1010, 1'b0, 3'b100};
        vecs[11] = '{3'b001, 1'b0, 4'b0100, 4'b0001, 4'b0010, 1'b1, 3'b001};

        reset = 1'b1; data_in = '0; op = 3'b000; cin = 1'b0; isl = 1'b0; isr = 1'b0;
        sel_a = 1'b0; wr = 1'b0; adr = '0; v = '0; sh_start = 1'b0; sh_dir = 1'b0; sh_cnt = '0;

        // Outputs while reset is held
        repeat (2) @(posedge clock);
        #1;
        expect_v("rst_R", 0);     check(R);
        expect_v("rst_cout", 0);  check(cout);
        expect_v("rst_flags", 0); check(flags);
        expect_v("rst_busy", 0);  check(busy);
        expect_v("rst_done", 0);  check(done);
        expect_v("rst_osl", 0);   check(osl);
        expect_v("rst_osr", 0);   check(osr);
        reset = 1'b0;
        tick();

        // Single left shift of regB
        set_ab(4'b0000, 4'b1001);
        isl = 1'b1; v = 3'b010;
        tick();
        v = 3'b000; op = 3'b111;
        expect_v("shl1_regB", 4'b0011); expect_v("shl1_osl", 1); expect_v("shl1_osr", 0);
        #1;
        check(R); check(osl); check(osr);

        // ALU table with flags captured on a write
        for (int i = 0; i < 12; i++) begin
            set_ab(vecs[i].a, vecs[i].b);
            op = vecs[i].op; cin = vecs[i].cin;
            expect_v($sformatf("alu%0d_R", i), vecs[i].r);
            expect_v($sformatf("alu%0d_cout", i), vecs[i].co);
            #1;
            check(R); check(cout);
            wr = 1'b1; adr = 3'd0;
            expect_v($sformatf("alu%0d_flags", i), vecs[i].fl);
            tick();
            wr = 1'b0;
            check(flags);
        end

        // Three-step right shift with v=100 held throughout
        set_ab(4'b0000, 4'b1011);
        isr = 1'b0; sh_dir = 1'b1; sh_cnt = 3'd3; sh_start = 1'b1; v = 3'b100;
        tick();
        sh_start = 1'b0;
        run_shift(3, 1'b0, "shr3");
        op = 3'b111;
        expect_v("shr3_regB", 4'b0001); expect_v("shr3_osr", 0); expect_v("shr3_osl_held", 1);
        #1;
        check(R); check(osr); check(osl);

        // Clear osl so the clamped shift must set it
        set_ab(4'b0000, 4'b0111);
        isl = 1'b0; v = 3'b010;
        tick();
        v = 3'b000;
        expect_v("osl_cleared", 0);
        check(osl);

        // Count 7 clamps to 4; sh_start pokes while busy are ignored
        set_ab(4'b0000, 4'b1111);
        isl = 1'b0; sh_dir = 1'b0; sh_cnt = 3'd7; sh_start = 1'b1;
        tick();
        sh_start = 1'b0;
        run_shift(4, 1'b1, "clamp");
        op = 3'b111;
        expect_v("clamp_regB", 4'b0000); expect_v("clamp_osl", 1);
        #1;
        check(R); check(osl);

        // Zero count: straight to the done pulse, regB untouched
        set_ab(4'b0000, 4'b0110);
        sh_cnt = 3'd0; sh_start = 1'b1;
        tick();
        sh_start = 1'b0;
        run_shift(0, 1'b0, "zero");
        op = 3'b111;
        expect_v("zero_regB", 4'b0110);
        #1;
        check(R);

        // Reset in the middle of a shift
        set_ab(4'b0101, 4'b1011);
        sh_dir = 1'b1; sh_cnt = 3'd3; sh_start = 1'b1;
        tick();
        sh_start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        expect_v("mid_rst_busy", 0);  check(busy);
        expect_v("mid_rst_done", 0);  check(done);
        expect_v("mid_rst_flags", 0); check(flags);
        expect_v("mid_rst_osr", 0);   check(osr);
        op = 3'b111; expect_v("mid_rst_regB", 0); #1; check(R);
        op = 3'b110; expect_v("mid_rst_regA", 0); #1; check(R);
        op = 3'b000; cin = 1'b0;
        expect_v("mid_rst_R_add", 0); expect_v("mid_rst_cout", 0);
        #1;
        check(R); check(cout);
        tick();
        expect_v("mid_rst_no_done", 0); check(done);
        reset = 1'b0;
        isl = 1'b1; sh_dir = 1'b0; sh_cnt = 3'd2; sh_start = 1'b1;
        tick();
        sh_start = 1'b0;
        expect_v("post_rst_start", 1); check(busy);
        run_shift(2, 1'b0, "post_rst");
        op = 3'b111;
        expect_v("post_rst_regB", 4'b0011);
        #1;
        check(R);
        v = 3'b110; adr = 3'd7;
        tick();
        v = 3'b000;
        expect_v("gpr7_cleared", 0);
        #1;
        check(R);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_ralu.md
PARAM_RALU -- requirements
Module: param_ralu

Interface
REQ-001 SHALL have parameter WIDTH, default 4: datapath width in bits; legal range 2..32.
REQ-002 SHALL have parameter DEPTH, default 8: number of general-purpose registers (GPRs), a power of two, 2..64; AW = log2(DEPTH); CW = log2(WIDTH)+1.
REQ-003 SHALL have clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have data_in  input  WIDTH  external operand for regA.
REQ-006 SHALL have op  input  3  ALU operation select.
REQ-007 SHALL have cin  input  1  ALU carry-in.
REQ-008 SHALL have isl, isr  input  1 each  serial-in bits for left and right shifts.
REQ-009 SHALL have sel_a  input  1  regA source: 1 = data_in, 0 = GPR[adr].
REQ-010 SHALL have wr  input  1  GPR write enable.
REQ-011 SHALL have adr  input  AW  GPR address.
REQ-012 SHALL have v  input  3  v[0] loads regA; v[2:1] selects the regB action.
REQ-013 SHALL have sh_start, sh_dir, sh_cnt  input  1/1/CW  multi-shift request; direction (0 = left, 1 = right); shift count.
REQ-014 SHALL have R  output  WIDTH  combinational ALU result.
REQ-015 SHALL have cout  output  1  combinational ALU carry-out.
REQ-016 SHALL have osl, osr  output  1 each  registered shift-out bits.
REQ-017 SHALL have flags  output  3  registered {N, Z, C}.
REQ-018 SHALL have busy, done  output  1 each  multi-shift status.

Function
REQ-019 ALU ops SHALL be as follows; cout is 0 for all logic ops (010-111).
- 000: {cout,R} = A + B + cin.
- 001: {cout,R} = A + ~B + cin.
- 010: AND.  011: OR.  100: XOR.
- 101: ~A.  110: A.  111: B.
REQ-020 When v[0] = 1, regA SHALL load data_in if sel_a = 1, else GPR[adr].
REQ-021 In the IDLE state without a sh_start, v[2:1] SHALL act on regB as follows.
- 00: hold.
- 01: {osl, regB} <= {regB, isl}.
- 10: {regB, osr} <= {isr, regB}.
- 11: regB <= GPR[adr].
REQ-022 osl and osr SHALL hold their value except on a shift in the matching direction.
REQ-023 When wr = 1, GPR[adr] <= R and flags <= {R[WIDTH-1], R==0, cout}; flags SHALL hold otherwise.
REQ-024 All loads in one cycle SHALL use pre-edge values: R is computed from the old regA/regB, and GPR reads return old contents even when wr targets the same adr.
REQ-025 The multi-shift FSM SHALL have states IDLE, SHIFT and DONE; busy = (state == SHIFT) and done = (state == DONE).
REQ-026 In IDLE with sh_start = 1, the FSM SHALL latch sh_dir and set cnt = min(sh_cnt, WIDTH); it goes to SHIFT if cnt > 0, else to DONE.
REQ-027 sh_start SHALL take priority over v[2:1] in the same cycle; v[2:1] is ignored that cycle.
REQ-028 In SHIFT, each cycle SHALL perform one shift in the latched direction, with the REQ-021 serial-in/out semantics, and decrement cnt; the FSM goes to DONE after the shift that takes cnt from 1 to 0.
REQ-029 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-030 A request of N > 0 shifts SHALL give busy for exactly N cycles, followed by a done pulse of 1 cycle.
REQ-031 While the FSM is not in IDLE, v[2:1] and sh_start SHALL be ignored; v[0] and wr remain fully functional.

Reset
REQ-032 While reset is high, regA, regB, all GPRs, osl, osr, flags and cnt SHALL be 0, the FSM SHALL be in IDLE, and busy = done = 0, independent of clock.
REQ-033 Reset asserted mid-shift SHALL abort the shift with no done pulse; after release the block accepts a new sh_start on the first edge.

Verification (WIDTH=4, DEPTH=8)
REQ-034 Reset mid-run -> all outputs and state 0; R = 0000 with op=000, cin=0; busy = done = 0.
REQ-035 Load and add -> expect R = 1010, cout = 0, flags = {1,0,0}.
- data_in=0101, sel_a=1, v=001: regA = 0101.
- op=110, wr, adr=3: GPR[3] = 0101.
- v=110, adr=3: regB = 0101.
- op=000, cin=0, wr, adr=1: check R, cout, flags.
REQ-036 regA=0011, regB=0101, op=001, cin=1, wr -> R = 1110, cout = 0, flags = {1,0,0}; then regA=regB=0101, op=001, cin=1 -> R = 0000, cout = 1, flags = {0,1,1}.
REQ-037 regB=1001, isl=1, v=010 -> regB = 0011, osl = 1, osr unchanged.
REQ-038 Multi-shift right -> busy high 3 cycles, then done 1 cycle; final regB = 0001, osr = 0.
- regB=1011, sh_start, sh_dir=1, sh_cnt=3, isr=0.
- v=100 held during the shift: no effect.
REQ-039 Clamp, ignore and zero-count cases.
- regB=1111, sh_dir=0, sh_cnt=7, isl=0 -> busy 4 cycles, regB = 0000, osl = 1.
- sh_start re-asserted while busy -> ignored.
- sh_cnt=0 -> no busy, done pulse on the next cycle, regB unchanged.
